sistema_ula_param: RTL and testbench
====================================

SISTEMA_ULA_PARAM -- requirements
Module: sistema_ula_param

Interface
REQ-001 SHALL have parameter W, default 3, operand width (legal 3..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, push_button synchroniser depth.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port push_button  input  1  asynchronous step button, active-high.
REQ-006 SHALL have port switches  input  W  operand/opcode entry (opcode = switches[2:0]).
REQ-007 SHALL have port FINAL_RESULT  output  2W  registered result.
REQ-008 SHALL have ports FINAL_LED_ZERO, FINAL_LED_NEG, FINAL_LED_OVERFLOW  output  1 each  registered flags.
REQ-009 SHALL have port busy  output  1  high while in CALC.
REQ-010 SHALL have port step  output  3  current state encoding, for LEDs.

Function
REQ-011 SHALL synchronise push_button through SYNC_STAGES flops; one press = one-cycle pulse on the synchronised rising edge.
REQ-012 SHALL implement states IDLE(0), LD_A(1), LD_B(2), LD_OP(3), ARM(4), CALC(5), SHOW(6).
REQ-013 IDLE + press: clear A, B, OP, FINAL_RESULT, all flags; go LD_A.
REQ-014 LD_A + press: A <= switches; go LD_B. LD_B + press: B <= switches; go LD_OP.
REQ-015 LD_OP + press: OP <= switches[2:0]; go ARM. ARM + press: go CALC.
REQ-016 Opcodes: 000 add, 001 sub, 010 mul, 011 div (quotient), 100 AND, 101 OR, 110 XOR, 111 mod (remainder).
REQ-017 Add/logic: zero-extended to 2W; sub: A-B as 2W two's complement, FINAL_LED_NEG=1 iff A<B.
REQ-018 Mul: unsigned A*B, 2W bits, never overflows.
REQ-019 Div/mod: unsigned restoring division; B=0 -> FINAL_RESULT=0, FINAL_LED_OVERFLOW=1, NEG=0.
REQ-020 Add/sub/logic/div-by-zero: outputs updated and state SHOW on the first clk edge after entering CALC.
REQ-021 Mul/div/mod with B!=0: outputs updated and state SHOW exactly W+1 clk edges after entering CALC.
REQ-022 FINAL_LED_ZERO = 1 iff the new FINAL_RESULT is zero (including opcode 111 with zero remainder).
REQ-023 Outputs SHALL hold unchanged from CALC exit through SHOW and IDLE until the next IDLE press clears them.
REQ-024 SHOW + press: go IDLE.
REQ-025 Presses during CALC SHALL be ignored, not queued.
REQ-026 Switch changes outside a load press SHALL have no effect.

Reset
REQ-027 reset=0 at a clk edge SHALL force IDLE, A=B=OP=0, FINAL_RESULT=0, all flags 0, busy=0, synchroniser cleared.
REQ-028 Reset mid-CALC SHALL abort the operation; no partial result reaches outputs.
REQ-029 A button held high through reset release SHALL NOT produce a press.

Structure
REQ-030 Opcode and state encodings SHALL live in a shared package (ula_pkg), used by RTL and bench.
REQ-031 Iterative multiply/divide SHALL be one sub-module ula_seq_muldiv (start, done, W-step shift-add / restoring divide).
REQ-032 Flag derivation and the state machine SHALL remain in sistema_ula_param.

Verification
REQ-033 W=3: 3+2 -> FINAL_RESULT=5, ZERO=0, NEG=0, OVF=0, one cycle after CALC.
REQ-034 W=3: 1-4 -> FINAL_RESULT=6'b111101, NEG=1.
REQ-035 W=3: 7*7 -> 49 after exactly 4 cycles in CALC; W=8: 255*255 -> 65025 after 9.
REQ-036 W=3: 5/0 -> result 0, OVF=1; 7 mod 3 -> 1; 6 mod 3 -> 0, ZERO=1.
REQ-037 Press during a mul CALC -> ignored, SHOW reached on schedule, next press returns IDLE.
REQ-038 reset=0 two cycles into a div CALC -> IDLE, all outputs 0; fresh 6-press 6/2 sequence -> 3.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared encodings for the stepped ALU: FSM state numbering (shown on the
// step LEDs) and the 3-bit opcode map entered on the switches.
package ula_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_A  = 3'd1,
    S_LD_B  = 3'd2,
    S_LD_OP = 3'd3,
    S_ARM   = 3'd4,
    S_CALC  = 3'd5,
    S_SHOW  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MOD = 3'b111
  } opcode_e;

  // Opcodes served by the multi-cycle multiply/divide unit.
  function automatic logic is_iterative(opcode_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/sistema_ula_param_if.sv
// Start/done handshake between the control FSM and the iterative
// multiply/divide unit.
interface ula_md_if import ula_pkg::*; #(
  parameter int W = 3
) ();
  logic             start;
  opcode_e          op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             done;
  logic [2*W-1:0]   result;

  modport master (output start, op, a, b, input done, result);
  modport slave  (input start, op, a, b, output done, result);
endinterface

// File: rtl/sistema_ula_param_muldiv.sv
// Iterative unsigned unit: W-step shift-add multiply or W-step restoring
// divide. done rises W edges after start and stays until the next edge.
module ula_seq_muldiv import ula_pkg::*; #(
  parameter int W = 3
) (
  input  logic     clk,
  input  logic     reset,
  ula_md_if.slave  md
);
  localparam int CW = $clog2(W + 1);

  logic           run_q, run_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mul_q, mul_d;
  logic           mod_q, mod_d;
  logic [2*W-1:0] acc_q, acc_d;      // product accumulator
  logic [2*W-1:0] mcand_q, mcand_d;  // shifted multiplicand
  logic [W-1:0]   sh_q, sh_d;        // multiplier bits / dividend->quotient
  logic [W-1:0]   rem_q, rem_d;      // partial remainder
  logic [W-1:0]   dvs_q, dvs_d;      // divisor
  logic [W:0]     rem_sh;
  logic [W:0]     diff;

  // One iteration per clock: load on start, step while count is non-zero.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    run_d   = run_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    mod_d   = mod_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    rem_sh  = {rem_q, sh_q[W-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    if (md.start) begin
      run_d   = 1'b1;
      cnt_d   = CW'(W);
      mul_d   = (md.op == OP_MUL);
      mod_d   = (md.op == OP_MOD);
      acc_d   = '0;
      mcand_d = {{W{1'b0}}, md.a};
      sh_d    = (md.op == OP_MUL) ? md.b : md.a;
      rem_d   = '0;
      dvs_d   = md.b;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
        if (mul_q) begin
          if (sh_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          sh_d    = sh_q >> 1;
        end else if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = diff[W-1:0];
          sh_d  = {sh_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[W-1:0];
          sh_d  = {sh_q[W-2:0], 1'b0};
        end
      end else begin
        run_d = 1'b0;
      end
    end
  end

  assign md.done   = run_q && (cnt_q == '0);
  assign md.result = mul_q ? acc_q : {{W{1'b0}}, (mod_q ? rem_q : sh_q)};

  // Datapath registers; a synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      run_q   <= 1'b0;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      mod_q   <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      sh_q    <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      mod_q   <= mod_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
    end
  end

endmodule

// File: rtl/sistema_ula_param.sv
// Button-stepped ALU: press to walk IDLE -> load A -> load B -> load opcode
// -> arm -> calculate -> show. Results and flags are registered and held.
module sistema_ula_param import ula_pkg::*; #(
  parameter int W           = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_button,
  input  logic [W-1:0]     switches,
  output logic [2*W-1:0]   FINAL_RESULT,
  output logic             FINAL_LED_ZERO,
  output logic             FINAL_LED_NEG,
  output logic             FINAL_LED_OVERFLOW,
  output logic             busy,
  output logic [2:0]       step
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;   // marks real samples in sync_q
  logic                   armed_q, armed_d; // set once a genuine low is seen
  logic                   prev_q, prev_d;
  logic                   sync_hi;
  logic                   press;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  opcode_e        op_q, op_d;
  logic [2*W-1:0] result_q, result_d;
  logic           zero_q, zero_d;
  logic           neg_q, neg_d;
  logic           ovf_q, ovf_d;

  logic [2*W-1:0] a_ext, b_ext, calc_res;
  logic           calc_neg, calc_ovf, need_seq, start;

  ula_md_if #(.W(W)) md ();

  ula_seq_muldiv #(.W(W)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  assign md.start = start;
  assign md.op    = op_q;
  assign md.a     = a_q;
  assign md.b     = b_q;

  // Button synchroniser and rising-edge detector. A button already high
  // when reset releases is not a press: a real low must be seen first.
  always_comb begin
    sync_hi = sync_q[SYNC_STAGES-1];
    sync_d  = {sync_q[SYNC_STAGES-2:0], push_button};
    fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
    armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~sync_hi);
    prev_d  = sync_hi;
    press   = armed_q & sync_hi & ~prev_q;
  end

  assign a_ext    = {{W{1'b0}}, a_q};
  assign b_ext    = {{W{1'b0}}, b_q};
  assign need_seq = is_iterative(op_q) && (b_q != '0);

  // Single-cycle result; iterative opcodes take the muldiv result instead.
  always_comb begin
    calc_res = '0;
    calc_neg = 1'b0;
    calc_ovf = 1'b0;
    case (op_q)
      OP_ADD: calc_res = a_ext + b_ext;
      OP_SUB: begin
        calc_res = a_ext - b_ext;
        calc_neg = (a_q < b_q);
      end
      OP_AND: calc_res = a_ext & b_ext;
      OP_OR:  calc_res = a_ext | b_ext;
      OP_XOR: calc_res = a_ext ^ b_ext;
      default: begin
        if (b_q == '0) begin
          calc_res = '0;
          calc_ovf = (op_q != OP_MUL);
        end else begin
          calc_res = md.result;
        end
      end
    endcase
  end

  // Next-state and register-load logic of the stepping FSM.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    start    = 1'b0;
    case (state_q)
      S_IDLE: if (press) begin
        a_d      = '0;
        b_d      = '0;
        op_d     = OP_ADD;
        result_d = '0;
        zero_d   = 1'b0;
        neg_d    = 1'b0;
        ovf_d    = 1'b0;
        state_d  = S_LD_A;
      end
      S_LD_A: if (press) begin
        a_d     = switches;
        state_d = S_LD_B;
      end
      S_LD_B: if (press) begin
        b_d     = switches;
        state_d = S_LD_OP;
      end
      S_LD_OP: if (press) begin
        op_d    = opcode_e'(switches[2:0]);
        state_d = S_ARM;
      end
      S_ARM: if (press) begin
        start   = need_seq;
        state_d = S_CALC;
      end
      S_CALC: if (!need_seq || md.done) begin
        result_d = calc_res;
        zero_d   = (calc_res == '0);
        neg_d    = calc_neg;
        ovf_d    = calc_ovf;
        state_d  = S_SHOW;
      end
      S_SHOW: if (press) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q   <= '0;
      fill_q   <= '0;
      armed_q  <= 1'b0;
      prev_q   <= 1'b0;
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      fill_q   <= fill_d;
      armed_q  <= armed_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign FINAL_RESULT       = result_q;
  assign FINAL_LED_ZERO     = zero_q;
  assign FINAL_LED_NEG      = neg_q;
  assign FINAL_LED_OVERFLOW = ovf_q;
  assign busy               = (state_q == S_CALC);
  assign step               = state_q;

endmodule

// File: tb/tb_sistema_ula_param.sv
// Directed bench: a W=3 and a W=8 instance share clock, reset, button and
// switches (the W=3 unit sees the low three switch bits) and step in lockstep.
module tb_sistema_ula_param;
  import ula_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       push_button;
  logic [7:0] sw8;
  logic [2:0] sw3;

  logic [5:0]  res3;
  logic        z3, n3, o3, busy3;
  logic [2:0]  step3;
  logic [15:0] res8;
  logic        z8, n8, o8, busy8;
  logic [2:0]  step8;

  int checks = 0;
  int errors = 0;
  int c3, c8;

  assign sw3 = sw8[2:0];

  always #5 clk = ~clk;

  sistema_ula_param #(.W(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .reset(reset), .push_button(push_button), .switches(sw3),
    .FINAL_RESULT(res3), .FINAL_LED_ZERO(z3), .FINAL_LED_NEG(n3),
    .FINAL_LED_OVERFLOW(o3), .busy(busy3), .step(step3)
  );

  sistema_ula_param #(.W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .push_button(push_button), .switches(sw8),
    .FINAL_RESULT(res8), .FINAL_LED_ZERO(z8), .FINAL_LED_NEG(n8),
    .FINAL_LED_OVERFLOW(o8), .busy(busy8), .step(step8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Clean press: high long enough to pass the synchroniser, then low.
  task automatic press();
    push_button = 1'b1;
    repeat (4) @(negedge clk);
    push_button = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // From LD_A: load A, B and opcode, ending in ARM.
  task automatic load_ops(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    sw8 = a; press();
    sw8 = b; press();
    sw8 = op; press();
  endtask

  // Arm press into CALC, then count edges until each unit shows SHOW.
  // With poke set, a second full press is made while still in CALC.
  task automatic run_calc(input bit poke, output int n3c, output int n8c);
    int n;
    n = 0;
    push_button = 1'b1;
    while (step3 != S_CALC && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("enter_calc", step3, S_CALC);
    check("busy_in_calc", busy3, 1'b1);
    push_button = 1'b0;
    n3c = -1;
    n8c = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (n3c < 0 && step3 == S_SHOW) n3c = k;
      if (n8c < 0 && step8 == S_SHOW) n8c = k;
      if (poke) push_button = (k == 1 || k == 2);
      if (n3c >= 0 && n8c >= 0 && k >= 4) break;
    end
    push_button = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    push_button = 1'b0;
    sw8 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("rst_step", step3, S_IDLE);
    check("rst_result", res3, 0);
    check("rst_flags", {z3, n3, o3}, 3'b000);
    check("rst_busy", busy3, 1'b0);
    check("rst_step8", step8, S_IDLE);
    repeat (4) @(negedge clk);

    // 3 + 2
    press();
    check("idle_to_lda", step3, S_LD_A);
    load_ops(8'd3, 8'd2, 8'(OP_ADD));
    check("armed", step3, S_ARM);
    run_calc(1'b0, c3, c8);
    check("add_cycles", c3, 1);
    check("add_result", res3, 5);
    check("add_flags", {z3, n3, o3}, 3'b000);
    sw8 = 8'd7;
    repeat (6) @(negedge clk);
    check("switch_no_effect", res3, 5);
    check("show_holds", step3, S_SHOW);
    press();
    check("show_to_idle", step3, S_IDLE);
    check("idle_holds_result", res3, 5);

    // 1 - 4
    press();
    check("idle_press_clears", res3, 0);
    load_ops(8'd1, 8'd4, 8'(OP_SUB));
    run_calc(1'b0, c3, c8);
    check("sub_cycles", c3, 1);
    check("sub_result", res3, 6'b111101);
    check("sub_flags", {z3, n3, o3}, 3'b010);
    press();

    // 7*7 on W=3, 255*255 on W=8, with a press made during CALC
    press();
    load_ops(8'd255, 8'd255, 8'(OP_MUL));
    run_calc(1'b1, c3, c8);
    check("mul3_cycles", c3, 4);
    check("mul8_cycles", c8, 9);
    check("mul3_result", res3, 49);
    check("mul8_result", res8, 65025);
    check("mul3_flags", {z3, n3, o3}, 3'b000);
    check("calc_press_ignored3", step3, S_SHOW);
    check("calc_press_ignored8", step8, S_SHOW);
    press();
    check("mul_show_to_idle", step3, S_IDLE);

    // 5 / 0
    press();
    load_ops(8'd5, 8'd0, 8'(OP_DIV));
    run_calc(1'b0, c3, c8);
    check("div0_cycles", c3, 1);
    check("div0_result", res3, 0);
    check("div0_flags", {z3, n3, o3}, 3'b101);
    press();

    // 7 mod 3
    press();
    load_ops(8'd7, 8'd3, 8'(OP_MOD));
    run_calc(1'b0, c3, c8);
    check("mod73_cycles", c3, 4);
    check("mod73_result", res3, 1);
    check("mod73_flags", {z3, n3, o3}, 3'b000);
    press();

    // 6 mod 3
    press();
    load_ops(8'd6, 8'd3, 8'(OP_MOD));
    run_calc(1'b0, c3, c8);
    check("mod63_result", res3, 0);
    check("mod63_zero", z3, 1'b1);
    press();

    // 5 xor 3, then reset while showing a non-zero result
    press();
    load_ops(8'd5, 8'd3, 8'(OP_XOR));
    run_calc(1'b0, c3, c8);
    check("xor_result", res3, 6);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("show_reset_result", res3, 0);
    check("show_reset_step", step3, S_IDLE);
    repeat (4) @(negedge clk);

    // 7 / 2 aborted by reset two cycles into CALC, button held through reset
    press();
    load_ops(8'd7, 8'd2, 8'(OP_DIV));
    push_button = 1'b1;
    for (int k = 0; k < 10 && step3 != S_CALC; k++) @(negedge clk);
    check("div_enter_calc", step3, S_CALC);
    push_button = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_button = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    check("abort_step", step3, S_IDLE);
    check("abort_result", res3, 0);
    check("abort_flags", {z3, n3, o3, busy3}, 4'b0000);
    repeat (8) @(negedge clk);
    check("held_button_no_press", step3, S_IDLE);
    check("abort_no_late_result", res3, 0);
    push_button = 1'b0;
    repeat (4) @(negedge clk);

    // Fresh 6 / 2
    press();
    load_ops(8'd6, 8'd2, 8'(OP_DIV));
    run_calc(1'b0, c3, c8);
    check("div62_cycles", c3, 4);
    check("div62_result", res3, 3);
    check("div62_flags", {z3, n3, o3}, 3'b000);
    check("div62_result8", res8, 3);
    press();
    check("final_idle", step3, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
